sha256_msg_padder: RTL and testbench

Upstream feeder for the 64-round SHA-256 compression pipeline. Accepts a message as a stream of 64-bit beats and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. Emits complete 512-bit chunks with a valid/ready handshake. Each chunk uses the compression stage's word layout: message word j at chunk[32*j+:32].

---
 rtl/sha256_msg_padder.sv | 148 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 64-bit message beats into 512-bit chunks and
// appends the 0x80 marker, zero fill and the 64-bit big-endian bit length.
// Message word j is carried at chunk[32*j +: 32].
// Optional feature macro: SHA_PAD_CHUNK_CNT_EN adds the chunk_count output.
module sha256_msg_padder #(
    parameter int CHUNKSIZE = 512,
    parameter int IN_W      = 64,
    parameter int LEN_W     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    input  logic                 in_last,
    input  logic [3:0]           in_bytes,
    output logic                 chunk_valid,
    input  logic                 chunk_ready,
    output logic [CHUNKSIZE-1:0] chunk,
    output logic                 chunk_last
`ifdef SHA_PAD_CHUNK_CNT_EN
    ,
    output logic [31:0]          chunk_count
`endif
);

    typedef enum logic [1:0] {S_FILL, S_EMIT, S_PAD} state_t;

    state_t               state;
    logic [2:0]           slot;
    logic [LEN_W-1:0]     length;
    logic                 pad_pend;
    logic                 marker;
    logic [CHUNKSIZE-1:0] buffer;

    logic [3:0]           n;
    logic [6:0]           off;
    logic [IN_W-1:0]      beat;
    logic [LEN_W-1:0]     len_last;
    logic [63:0]          len_field;
    logic [63:0]          pad_field;

    assign chunk = buffer;

    // Final-beat shaping: keep the first n bytes, place 0x80 at byte n, zero the rest.
    always_comb begin
        n         = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        off       = {1'b0, slot, 3'b000} + {3'b000, n};
        len_last  = length + LEN_W'({n, 3'b000});
        len_field = 64'(len_last);
        pad_field = 64'(length);
        beat      = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < 32'(n))
                beat[32*(k/4) + 31 - 8*(k%4) -: 8] = in_data[32*(k/4) + 31 - 8*(k%4) -: 8];
            else if (k == 32'(n))
                beat[32*(k/4) + 31 - 8*(k%4) -: 8] = 8'h80;
        end
    end

    // Fill / emit / pad sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_FILL;
            slot        <= '0;
            length      <= '0;
            buffer      <= '0;
            pad_pend    <= 1'b0;
            marker      <= 1'b0;
            in_ready    <= 1'b0;
            chunk_valid <= 1'b0;
            chunk_last  <= 1'b0;
`ifdef SHA_PAD_CHUNK_CNT_EN
            chunk_count <= '0;
`endif
        end else begin
            case (state)
                S_FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (!in_last) begin
                            buffer[{slot, 6'b000000} +: 64] <= in_data;
                            length <= length + LEN_W'(64);
                            slot   <= slot + 3'd1;
                            if (slot == 3'd7) begin
                                state       <= S_EMIT;
                                in_ready    <= 1'b0;
                                chunk_valid <= 1'b1;
                                chunk_last  <= 1'b0;
                                pad_pend    <= 1'b0;
                            end
                        end else begin
                            buffer[{slot, 6'b000000} +: 64] <= beat;
                            length      <= len_last;
                            state       <= S_EMIT;
                            in_ready    <= 1'b0;
                            chunk_valid <= 1'b1;
                            // A full final beat leaves the marker for the next word pair.
                            if (n == 4'd8 && slot != 3'd7)
                                buffer[{slot + 3'd1, 6'b000000} +: 32] <= 32'h80000000;
                            if (off <= 7'd55) begin
                                buffer[479:448] <= len_field[63:32];
                                buffer[511:480] <= len_field[31:0];
                                chunk_last      <= 1'b1;
                                pad_pend        <= 1'b0;
                            end else begin
                                chunk_last <= 1'b0;
                                pad_pend   <= 1'b1;
                                marker     <= (off == 7'd64);
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (chunk_ready) begin
                        chunk_valid <= 1'b0;
                        chunk_last  <= 1'b0;
`ifdef SHA_PAD_CHUNK_CNT_EN
                        chunk_count <= chunk_count + 32'd1;
`endif
                        if (chunk_last)
                            length <= '0;
                        if (pad_pend) begin
                            state <= S_PAD;
                        end else begin
                            state    <= S_FILL;
                            slot     <= '0;
                            buffer   <= '0;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    buffer          <= '0;
                    buffer[31:0]    <= marker ? 32'h80000000 : 32'h0;
                    buffer[479:448] <= pad_field[63:32];
                    buffer[511:480] <= pad_field[31:0];
                    chunk_last      <= 1'b1;
                    chunk_valid     <= 1'b1;
                    pad_pend        <= 1'b0;
                    state           <= S_EMIT;
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed testbench for sha256_msg_padder. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Set SHA_PAD_CHUNK_CNT_EN to also
// exercise chunk_count.
module tb_sha256_msg_padder;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_last;
    logic [3:0]   in_bytes;
    logic         chunk_valid;
    logic         chunk_ready;
    logic [511:0] chunk;
    logic         chunk_last;
`ifdef SHA_PAD_CHUNK_CNT_EN
    logic [31:0]  chunk_count;
    logic [31:0]  cnt_before;
`endif

    int unsigned  tests;
    int unsigned  fails;
    logic [31:0]  ew [16];
    logic [511:0] exp_abc;
    logic [511:0] held;

    sha256_msg_padder #(
        .CHUNKSIZE(512),
        .IN_W(64),
        .LEN_W(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .in_bytes(in_bytes),
        .chunk_valid(chunk_valid),
        .chunk_ready(chunk_ready),
        .chunk(chunk),
        .chunk_last(chunk_last)
`ifdef SHA_PAD_CHUNK_CNT_EN
        ,
        .chunk_count(chunk_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 16; i++) ew[i] = 32'h0;
    endtask

    function automatic logic [511:0] exp_chunk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = ew[i];
        return r;
    endfunction

    // Present one beat and hold it until the padder takes it.
    task automatic send_beat(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int unsigned cnt;
        cnt      = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("in_ready_timeout", 512'(in_ready), 512'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 4'd0;
    endtask

    // Wait for a chunk, compare it, then accept it.
    task automatic expect_chunk(input string tag, input logic [511:0] ec, input logic el);
        int unsigned cnt;
        cnt = 0;
        while (!chunk_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_valid"}, 512'(chunk_valid), 512'(1));
        check({tag, "_data"}, chunk, ec);
        check({tag, "_last"}, 512'(chunk_last), 512'(el));
        chunk_ready = 1'b1;
        @(negedge clk);
        chunk_ready = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        in_bytes    = 4'd0;
        chunk_ready = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_chunk_valid", 512'(chunk_valid), 512'(0));
        check("rst_chunk_last", 512'(chunk_last), 512'(0));
        check("rst_chunk", chunk, 512'(0));
`ifdef SHA_PAD_CHUNK_CNT_EN
        check("rst_count", 512'(chunk_count), 512'(0));
`endif
        reset = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 512'(in_ready), 512'(1));

        // "abc"
        clr_exp();
        ew[0]  = 32'h61626380;
        ew[15] = 32'h00000018;
        exp_abc = exp_chunk();
        send_beat(64'h00000000_61626300, 1'b1, 4'd3);
        check("abc_latency", 512'(chunk_valid), 512'(1));
        expect_chunk("abc", exp_abc, 1'b1);

        // 56-byte message: marker lands in word 14, length spills to a pad chunk
        clr_exp();
        for (int i = 0; i < 7; i++)
            send_beat({32'h10000000 + 32'(2*i+1), 32'h10000000 + 32'(2*i)}, i == 6, 4'd8);
        for (int j = 0; j < 14; j++) ew[j] = 32'h10000000 + 32'(j);
        ew[14] = 32'h80000000;
        expect_chunk("b56_c1", exp_chunk(), 1'b0);
        check("b56_pad_gap", 512'(chunk_valid), 512'(0));
        @(negedge clk);
        check("b56_pad_latency", 512'(chunk_valid), 512'(1));
        clr_exp();
        ew[15] = 32'h000001C0;
        expect_chunk("b56_c2", exp_chunk(), 1'b0 | 1'b1);

        // 64-byte message: raw chunk, then marker+length chunk
        clr_exp();
        for (int i = 0; i < 8; i++)
            send_beat({32'h20000000 + 32'(2*i+1), 32'h20000000 + 32'(2*i)}, i == 7, 4'd8);
        for (int j = 0; j < 16; j++) ew[j] = 32'h20000000 + 32'(j);
        expect_chunk("b64_c1", exp_chunk(), 1'b0);
        clr_exp();
        ew[0]  = 32'h80000000;
        ew[15] = 32'h00000200;
        expect_chunk("b64_c2", exp_chunk(), 1'b1);

        // Partial final beat, 5 bytes: marker inside the later word
        clr_exp();
        ew[0]  = 32'h55667788;
        ew[1]  = 32'h11800000;
        ew[15] = 32'h00000028;
        send_beat(64'h11223344_55667788, 1'b1, 4'd5);
        expect_chunk("b5", exp_chunk(), 1'b1);

        // in_bytes above 8 behaves as 8
        clr_exp();
        ew[0]  = 32'hA1A2A3A4;
        ew[1]  = 32'hB1B2B3B4;
        ew[2]  = 32'h80000000;
        ew[15] = 32'h00000040;
        send_beat(64'hB1B2B3B4_A1A2A3A4, 1'b1, 4'd15);
        expect_chunk("b15", exp_chunk(), 1'b1);

        // Backpressure on "abc"
        send_beat(64'h00000000_61626300, 1'b1, 4'd3);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 512'(chunk_valid), 512'(1));
            check("bp_chunk", chunk, exp_abc);
            check("bp_in_ready", 512'(in_ready), 512'(0));
            @(negedge clk);
        end
        expect_chunk("bp_accept", exp_abc, 1'b1);
        check("bp_done_valid", 512'(chunk_valid), 512'(0));

        // Reset while a chunk is pending
        send_beat(64'h00000000_61626300, 1'b1, 4'd3);
        check("mid_pending", 512'(chunk_valid), 512'(1));
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 512'(chunk_valid), 512'(0));
        check("mid_rst_chunk", chunk, 512'(0));
        check("mid_rst_in_ready", 512'(in_ready), 512'(0));
        reset = 1'b1;
        send_beat(64'h00000000_61626300, 1'b1, 4'd3);
        expect_chunk("abc_after_rst", exp_abc, 1'b1);

        // Empty message
        clr_exp();
        ew[0] = 32'h80000000;
`ifdef SHA_PAD_CHUNK_CNT_EN
        cnt_before = chunk_count;
`endif
        send_beat(64'h0, 1'b1, 4'd0);
        expect_chunk("empty", exp_chunk(), 1'b1);
`ifdef SHA_PAD_CHUNK_CNT_EN
        check("empty_count", 512'(chunk_count), 512'(cnt_before + 32'd1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
